mmio_uart_tx: RTL

- Memory-mapped UART transmitter that acts as a responder on the core's data-memory bus, the same r / w[3:0] / addr / in / out interface the RAM presents.
- The SoC decodes it beside the RAM. Software writes bytes into a TX FIFO, and the block serialises them 8N1 on a single tx line.
- It provides the first console output path for test programs, in addition to the memdump flow.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/mmio_uart_tx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register map,
// STATUS bit positions and serialiser states.
package uart_tx_pkg;

    localparam logic [1:0] TXDATA_OFF  = 2'd0;
    localparam logic [1:0] STATUS_OFF  = 2'd1;
    localparam logic [1:0] DIVISOR_OFF = 2'd2;

    localparam int unsigned ST_FULL  = 0;
    localparam int unsigned ST_EMPTY = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_OVF   = 3;
    localparam int unsigned ST_CNT_LO = 8;
    localparam int unsigned ST_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Bus-mapped 8N1 UART transmitter: register decode, TX FIFO and a
// bit-timed serialiser that chains frames without an idle gap.
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r,
    input  logic [3:0]  w,
    input  logic [31:0] addr,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        tx,
    output logic        tx_idle
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    logic [1:0]    off;
    logic          bus_wr;
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic [15:0]   divisor_q;
    logic          ovf_q;
    logic          ovf_clr;
    logic          div_wr;

    tx_state_e     state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [15:0]   timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic          tx_q, tx_d;

    logic          unused_bits;

    assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
    assign off       = addr[3:2];
    assign bus_wr    = sel && (w != 4'b0000);
    assign fifo_push = bus_wr && (off == TXDATA_OFF) && w[0];
    assign ovf_clr   = bus_wr && (off == STATUS_OFF) && w[0] && in[3];
    assign div_wr    = bus_wr && (off == DIVISOR_OFF);
    assign unused_bits = ^{in[31:16], w[3:2], addr[1:0]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Control registers: divisor per byte lane, sticky overflow on dropped push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divisor_q <= DIV_RESET;
            ovf_q     <= 1'b0;
        end else begin
            if (div_wr && w[0]) divisor_q[7:0]  <= in[7:0];
            if (div_wr && w[1]) divisor_q[15:8] <= in[15:8];
            if (fifo_push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
            else if (ovf_clr)                         ovf_q <= 1'b0;
        end
    end

    always_comb begin
        out = '0;
        if (r && sel) begin
            case (off)
                STATUS_OFF: begin
                    out[ST_FULL]  = fifo_full;
                    out[ST_EMPTY] = fifo_empty;
                    out[ST_BUSY]  = (state_q != IDLE);
                    out[ST_OVF]   = ovf_q;
                    out[ST_CNT_LO +: ST_CNT_W] = ST_CNT_W'(fifo_count);
                end
                DIVISOR_OFF: out[15:0] = divisor_q;
                default:     out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            timer_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    // Serialiser: each bit holds for divisor+1 clocks; the divisor is
    // sampled only at reload, so a mid-frame change never truncates a bit.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    timer_d  = divisor_q;
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (timer_q == 16'd0) begin
                    timer_d = divisor_q;
                    tx_d    = shreg_q[0];
                    idx_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            DATA: begin
                if (timer_q == 16'd0) begin
                    timer_d = divisor_q;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            STOP: begin
                if (timer_q == 16'd0) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                        timer_d  = divisor_q;
                        tx_d     = 1'b0;
                        state_d  = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx      = tx_q;
    assign tx_idle = fifo_empty && (state_q == IDLE);

endmodule
